fc_control_gen: RTL and testbench
=================================

# fc_control_gen

Parametrised control sequencer for one fully-connected layer. It replaces fixed-width FC control with a start/busy/done handshake and an explicit state machine. It generalises the bank mux to any PI, and makes pipeline latencies parameters. It sits between the FC address generators, the input-neuron and weight M9K banks, and the dual-port MAC array. It generates the read enables, accumulator sload, step/group counters, bank-selected operands and per-group result strobes.

## Interface
- DATA_W, 16, operand width per lane
- PI, 4, number of input-neuron banks (any value ≥1)
- PO, 2, output neurons computed in parallel per group
- INNEURON, 1024, input neurons per output; even, and INNEURON/2 divisible by PI
- OUTNEURON, 10, output neurons; divisible by PO
- PRIME_LAT, 4, cycles from start acceptance to first valid operand (address gen + M9K read)
- ACC_LAT, 3, cycles from last MAC step of a group to valid accumulator result
- Derived: STEPS=INNEURON/2, SEG=STEPS/PI, GROUPS=OUTNEURON/PO; STEPS ≥ 2
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin one layer pass; sampled only in IDLE
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at pass completion
- addr_en  out  1  enable for neuron and weight address generators
- rden  out  1  read enable to neuron ports a/b and weight ports a/b (write enables are not driven by this block)
- mult_en  out  1  MAC clock enable
- accum_sload  out  1  load (not add) accumulator this cycle
- count_sload  out  clog2(STEPS)  step within current group
- count_out  out  clog2(GROUPS+1)  completed groups
- in_q_a_all, in_q_b_all  in  DATA_W*PI  concatenated bank outputs; bank p = bits [p*DATA_W +: DATA_W]
- q_a_mux, q_b_mux  out  DATA_W  selected operand
- acc_valid  out  1  one-cycle strobe: group result valid at MAC output

## Operation
- States: IDLE → PRIME → RUN → DRAIN → DONE → IDLE.
- IDLE: all outputs 0 except count_out, which holds its last value. On start=1, clear count_out and count_sload, then enter PRIME.
- PRIME: addr_en=rden=1. Stay PRIME_LAT cycles, then enter RUN.
- RUN: addr_en=rden=mult_en=1.
  - count_sload increments every cycle and wraps STEPS-1 → 0.
  - On the wrap, count_out increments.
  - accum_sload = (count_sload==0).
  - When count_out reaches GROUPS-1 and count_sload==STEPS-1, enter DRAIN.
- DRAIN: mult_en=1 and addr_en=rden=0 for ACC_LAT cycles, then enter DONE.
- DONE: done=1 for one cycle, then enter IDLE.
- Bank select is sel = count_sload / SEG. q_x_mux = bank[sel] in RUN, and 0 in every other state. This is fully generic in PI; there are no hard-coded bank counts.
- acc_valid is a one-cycle pulse issued ACC_LAT cycles after each cycle with count_sload==STEPS-1 in RUN, so it fires exactly GROUPS times per pass.
- start while busy: ignored; it is not queued.
- reset at any time: state=IDLE, all counters 0, all outputs 0, and the acc_valid pipeline is flushed.

## Timing
- start sampled at edge T. PRIME covers cycles T+1 … T+PRIME_LAT.
- First RUN cycle is T+PRIME_LAT+1, with accum_sload=1 and count_sload=0.
- RUN lasts exactly GROUPS*STEPS cycles.
- First acc_valid pulse: T+PRIME_LAT+STEPS+ACC_LAT.
- done pulse: T+PRIME_LAT+GROUPS*STEPS+ACC_LAT+1. busy drops the next cycle.
- Back-to-back: start asserted in the cycle immediately after done is accepted, with no bubble.
- All control outputs are registered. q_x_mux is combinational from count_sload and the state register only.

## Structure
- Shared package fc_gen_pkg holds the state enum (IDLE/PRIME/RUN/DRAIN/DONE) and the derived-constant functions (STEPS, SEG, GROUPS, counter widths).
- Sub-module fc_bank_mux (PI-way parametrised select, zero-when-idle) is instantiated twice, for ports a and b.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
Common settings: PI=4, INNEURON=16, OUTNEURON=4, PO=2, PRIME_LAT=4, ACC_LAT=3, so STEPS=8, SEG=2, GROUPS=2.
- Nominal pass: start at T=0 → accum_sload at T=5 and T=13; RUN from T=5 to T=20; acc_valid at T=15 and T=23; done at T=24; count_out=2.
- Bank mux: banks loaded with 0x0001/0x0002/0x0003/0x0004 → q_a_mux reads 1,1,2,2,3,3,4,4 per group, and 0 outside RUN.
- start pulsed at T=7 and T=20 during a pass → ignored; timing is identical to the nominal pass.
- Async reset asserted at T=10, mid-RUN → all outputs 0 within the same cycle; a new start after release gives nominal timing.
- Back-to-back: start held high continuously → second pass PRIME begins the cycle after DONE; count_out clears to 0 at the second start.
- PI=3, INNEURON=12, SEG=2 → select sequence 0,0,1,1,2,2; PI=1 → bank 0 only.

Source files
------------

// File: rtl/fc_gen_pkg.sv
// Shared types and derived-constant helpers for the fully-connected layer control sequencer.
// Counter widths and the bank-select rule live here so the top and its checks agree.
package fc_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } fc_state_e;

  function automatic int steps_f(input int inneuron);
    return inneuron / 32'sd2;
  endfunction

  function automatic int seg_f(input int inneuron, input int pi);
    return (pi > 32'sd0) ? steps_f(inneuron) / pi : 32'sd1;
  endfunction

  function automatic int groups_f(input int outneuron, input int po);
    return (po > 32'sd0) ? outneuron / po : 32'sd1;
  endfunction

  // Width needed to hold values 0..n-1, never narrower than one bit
  function automatic int clog2c_f(input int n);
    return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

  function automatic int cnt_w_f(input int inneuron);
    return clog2c_f(steps_f(inneuron));
  endfunction

  function automatic int grp_w_f(input int outneuron, input int po);
    return clog2c_f(groups_f(outneuron, po) + 32'sd1);
  endfunction

  function automatic int bank_sel_f(input int step, input int seg);
    return (seg > 32'sd0) ? step / seg : 32'sd0;
  endfunction

endpackage

// File: rtl/fc_bank_mux.sv
// PI-way operand select across concatenated M9K bank outputs.
// Output is forced to zero whenever en is low, so the MAC sees clean zeros outside RUN.
module fc_bank_mux #(
  parameter int DATA_W = 16,
  parameter int PI     = 4,
  parameter int SW     = 2
) (
  input  logic [DATA_W*PI-1:0] bank_all,
  input  logic [SW-1:0]        sel,
  input  logic                 en,
  output logic [DATA_W-1:0]    q
);

  // AND-OR select keeps the mux free of priority logic and out-of-range indexing
  always_comb begin
    q = {DATA_W{1'b0}};
    for (int p = 0; p < PI; p++) begin
      q = q | (bank_all[p*DATA_W +: DATA_W] & {DATA_W{en && (sel == SW'(p))}});
    end
  end

endmodule

// File: rtl/fc_gen_param_check.sv
// Elaboration-time legality checks for the fc_control_gen parameter set.
// Holds no logic; an illegal configuration stops elaboration with a message.
module fc_gen_param_check
  import fc_gen_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PI        = 4,
  parameter int PO        = 2,
  parameter int INNEURON  = 1024,
  parameter int OUTNEURON = 10,
  parameter int PRIME_LAT = 4,
  parameter int ACC_LAT   = 3
) ();

  if (DATA_W < 32'sd1) begin : g_bad_data_w
    $error("fc_control_gen: DATA_W must be at least 1");
  end
  if (PI < 32'sd1) begin : g_bad_pi
    $error("fc_control_gen: PI must be at least 1");
  end
  if (PO < 32'sd1) begin : g_bad_po
    $error("fc_control_gen: PO must be at least 1");
  end
  if ((INNEURON % 32'sd2) != 32'sd0) begin : g_bad_inneuron_odd
    $error("fc_control_gen: INNEURON must be even");
  end
  if ((PI >= 32'sd1) && ((steps_f(INNEURON) % PI) != 32'sd0)) begin : g_bad_seg
    $error("fc_control_gen: INNEURON/2 must be divisible by PI");
  end
  if (steps_f(INNEURON) < 32'sd2) begin : g_bad_steps
    $error("fc_control_gen: INNEURON/2 must be at least 2");
  end
  if ((PO >= 32'sd1) && (((OUTNEURON % PO) != 32'sd0) || (OUTNEURON < PO))) begin : g_bad_groups
    $error("fc_control_gen: OUTNEURON must be a non-zero multiple of PO");
  end
  if ((PRIME_LAT < 32'sd1) || (ACC_LAT < 32'sd1)) begin : g_bad_lat
    $error("fc_control_gen: PRIME_LAT and ACC_LAT must be at least 1");
  end

endmodule

// File: rtl/fc_control_gen.sv
// Start/busy/done control sequencer for one fully-connected layer pass:
// priming, per-group MAC stepping, accumulator drain and per-group result strobes.
module fc_control_gen
  import fc_gen_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PI        = 4,
  parameter int PO        = 2,
  parameter int INNEURON  = 1024,
  parameter int OUTNEURON = 10,
  parameter int PRIME_LAT = 4,
  parameter int ACC_LAT   = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                addr_en,
  output logic                                rden,
  output logic                                mult_en,
  output logic                                accum_sload,
  output logic [cnt_w_f(INNEURON)-1:0]        count_sload,
  output logic [grp_w_f(OUTNEURON, PO)-1:0]   count_out,
  input  logic [DATA_W*PI-1:0]                in_q_a_all,
  input  logic [DATA_W*PI-1:0]                in_q_b_all,
  output logic [DATA_W-1:0]                   q_a_mux,
  output logic [DATA_W-1:0]                   q_b_mux,
  output logic                                acc_valid
);

  localparam int STEPS  = steps_f(INNEURON);
  localparam int SEG    = seg_f(INNEURON, PI);
  localparam int GROUPS = groups_f(OUTNEURON, PO);
  localparam int CW     = cnt_w_f(INNEURON);
  localparam int OW     = grp_w_f(OUTNEURON, PO);
  localparam int SW     = clog2c_f(PI);
  localparam int TW     = clog2c_f((PRIME_LAT > ACC_LAT) ? PRIME_LAT : ACC_LAT);

  localparam logic [CW-1:0] STEP_LAST  = CW'(STEPS - 32'sd1);
  localparam logic [OW-1:0] GRP_LAST   = OW'(GROUPS - 32'sd1);
  localparam logic [TW-1:0] PRIME_LAST = TW'(PRIME_LAT - 32'sd1);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(ACC_LAT - 32'sd1);

  fc_gen_param_check #(
    .DATA_W(DATA_W), .PI(PI), .PO(PO), .INNEURON(INNEURON),
    .OUTNEURON(OUTNEURON), .PRIME_LAT(PRIME_LAT), .ACC_LAT(ACC_LAT)
  ) u_param_check ();

  fc_state_e        state_r, next_state_s;
  logic [TW-1:0]    tmr_r, tmr_n_s;
  logic [CW-1:0]    step_r, step_n_s;
  logic [OW-1:0]    grp_r, grp_n_s;
  logic [ACC_LAT-1:0] acc_pipe_r;
  logic             step_last_s, acc_push_s;
  logic             busy_r, done_r, addr_en_r, rden_r, mult_en_r, accum_sload_r;
  logic             busy_n_s, done_n_s, addr_en_n_s, rden_n_s, mult_en_n_s, accum_sload_n_s;
  logic [SW-1:0]    sel_s;
  logic             mux_en_s;

  assign step_last_s = (step_r == STEP_LAST);
  assign acc_push_s  = (state_r == ST_RUN) && step_last_s;

  // Next-state and step/group counter update
  always_comb begin
    next_state_s = state_r;
    step_n_s     = step_r;
    grp_n_s      = grp_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_PRIME;
          step_n_s     = {CW{1'b0}};
          grp_n_s      = {OW{1'b0}};
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (tmr_r == PRIME_LAST) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_PRIME;
        end
      end
      ST_RUN: begin
        if (step_last_s) begin
          step_n_s = {CW{1'b0}};
          grp_n_s  = grp_r + OW'(1'b1);
          if (grp_r == GRP_LAST) begin
            next_state_s = ST_DRAIN;
          end else begin
            next_state_s = ST_RUN;
          end
        end else begin
          step_n_s     = step_r + CW'(1'b1);
          next_state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (tmr_r == DRAIN_LAST) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Dwell timer for PRIME and DRAIN, restarted on every state change
  always_comb begin
    tmr_n_s = tmr_r;
    if (next_state_s != state_r) begin
      tmr_n_s = {TW{1'b0}};
    end else if ((state_r == ST_PRIME) || (state_r == ST_DRAIN)) begin
      tmr_n_s = tmr_r + TW'(1'b1);
    end else begin
      tmr_n_s = tmr_r;
    end
  end

  // Control outputs decoded from the next state so they can be registered
  always_comb begin
    addr_en_n_s     = 1'b0;
    rden_n_s        = 1'b0;
    mult_en_n_s     = 1'b0;
    accum_sload_n_s = 1'b0;
    done_n_s        = 1'b0;
    busy_n_s        = (next_state_s != ST_IDLE);
    case (next_state_s)
      ST_IDLE:  busy_n_s = 1'b0;
      ST_PRIME: begin
        addr_en_n_s = 1'b1;
        rden_n_s    = 1'b1;
      end
      ST_RUN: begin
        addr_en_n_s     = 1'b1;
        rden_n_s        = 1'b1;
        mult_en_n_s     = 1'b1;
        accum_sload_n_s = (step_n_s == {CW{1'b0}});
      end
      ST_DRAIN: mult_en_n_s = 1'b1;
      ST_DONE:  done_n_s    = 1'b1;
      default:  busy_n_s    = 1'b0;
    endcase
  end

  // State, counters, registered controls and the acc_valid delay line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      tmr_r         <= {TW{1'b0}};
      step_r        <= {CW{1'b0}};
      grp_r         <= {OW{1'b0}};
      acc_pipe_r    <= {ACC_LAT{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      addr_en_r     <= 1'b0;
      rden_r        <= 1'b0;
      mult_en_r     <= 1'b0;
      accum_sload_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      tmr_r         <= tmr_n_s;
      step_r        <= step_n_s;
      grp_r         <= grp_n_s;
      acc_pipe_r    <= ACC_LAT'({acc_pipe_r, acc_push_s});
      busy_r        <= busy_n_s;
      done_r        <= done_n_s;
      addr_en_r     <= addr_en_n_s;
      rden_r        <= rden_n_s;
      mult_en_r     <= mult_en_n_s;
      accum_sload_r <= accum_sload_n_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign addr_en     = addr_en_r;
  assign rden        = rden_r;
  assign mult_en     = mult_en_r;
  assign accum_sload = accum_sload_r;
  assign count_sload = step_r;
  assign count_out   = grp_r;
  assign acc_valid   = acc_pipe_r[ACC_LAT-1];

  // Operand select depends only on registered state, keeping M9K-to-MAC path short
  assign sel_s    = SW'(bank_sel_f(int'(step_r), SEG));
  assign mux_en_s = (state_r == ST_RUN);

  fc_bank_mux #(.DATA_W(DATA_W), .PI(PI), .SW(SW)) u_mux_a (
    .bank_all(in_q_a_all), .sel(sel_s), .en(mux_en_s), .q(q_a_mux)
  );

  fc_bank_mux #(.DATA_W(DATA_W), .PI(PI), .SW(SW)) u_mux_b (
    .bank_all(in_q_b_all), .sel(sel_s), .en(mux_en_s), .q(q_b_mux)
  );

endmodule

// File: tb/tb_fc_control_gen.sv
// Self-checking bench for fc_control_gen: timing tables built from the pass timing formulas,
// pushed through a scoreboard queue, plus hand sequences for resets and odd bank counts.
module tb_fc_control_gen;

  localparam int DW        = 16;
  localparam int P_LAT     = 4;
  localparam int A_LAT     = 3;
  localparam int STEPS     = 8;
  localparam int SEG       = 2;
  localparam int GROUPS    = 2;
  localparam int RUN_FIRST = P_LAT + 1;
  localparam int RUN_LAST  = P_LAT + GROUPS * STEPS;
  localparam int DONE_R    = RUN_LAST + A_LAT + 1;
  localparam int NV        = 80;

  logic clock = 1'b0;
  logic reset, start, start3, start1;
  logic busy, done, addr_en, rden, mult_en, accum_sload, acc_valid;
  logic [2:0] count_sload;
  logic [1:0] count_out;
  logic [4*DW-1:0] qa_all, qb_all;
  logic [DW-1:0] q_a_mux, q_b_mux;

  logic busy3, done3, addr_en3, rden3, mult_en3, accum_sload3, acc_valid3;
  logic [2:0] count_sload3;
  logic [0:0] count_out3;
  logic [3*DW-1:0] qa3_all, qb3_all;
  logic [DW-1:0] q_a3, q_b3;

  logic busy1, done1, addr_en1, rden1, mult_en1, accum_sload1, acc_valid1;
  logic [1:0] count_sload1;
  logic [1:0] count_out1;
  logic [DW-1:0] qa1_all, qb1_all;
  logic [DW-1:0] q_a1, q_b1;

  always #5 clock = ~clock;

  fc_control_gen #(.DATA_W(DW), .PI(4), .PO(2), .INNEURON(16), .OUTNEURON(4),
                   .PRIME_LAT(P_LAT), .ACC_LAT(A_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .addr_en(addr_en), .rden(rden), .mult_en(mult_en), .accum_sload(accum_sload),
    .count_sload(count_sload), .count_out(count_out), .in_q_a_all(qa_all),
    .in_q_b_all(qb_all), .q_a_mux(q_a_mux), .q_b_mux(q_b_mux), .acc_valid(acc_valid));

  fc_control_gen #(.DATA_W(DW), .PI(3), .PO(2), .INNEURON(12), .OUTNEURON(2),
                   .PRIME_LAT(P_LAT), .ACC_LAT(A_LAT)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .busy(busy3), .done(done3),
    .addr_en(addr_en3), .rden(rden3), .mult_en(mult_en3), .accum_sload(accum_sload3),
    .count_sload(count_sload3), .count_out(count_out3), .in_q_a_all(qa3_all),
    .in_q_b_all(qb3_all), .q_a_mux(q_a3), .q_b_mux(q_b3), .acc_valid(acc_valid3));

  fc_control_gen #(.DATA_W(DW), .PI(1), .PO(1), .INNEURON(8), .OUTNEURON(2),
                   .PRIME_LAT(P_LAT), .ACC_LAT(A_LAT)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .addr_en(addr_en1), .rden(rden1), .mult_en(mult_en1), .accum_sload(accum_sload1),
    .count_sload(count_sload1), .count_out(count_out1), .in_q_a_all(qa1_all),
    .in_q_b_all(qb1_all), .q_a_mux(q_a1), .q_b_mux(q_b1), .acc_valid(acc_valid1));

  typedef struct {
    logic          start;
    logic          busy;
    logic          done;
    logic          addr_en;
    logic          rden;
    logic          mult_en;
    logic          accum_sload;
    logic          acc_valid;
    logic [2:0]    count_sload;
    logic [1:0]    count_out;
    logic [DW-1:0] q_a;
    logic [DW-1:0] q_b;
  } vec_t;

  vec_t vec [NV];
  vec_t sb_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [NV-1:0] st_v;

  task automatic check(input string name, input int cyc, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Bank p holds p+1 on port a and (p+1)*16 on port b
  function automatic logic [DW-1:0] bank_val(input int sel, input bit port_b);
    return port_b ? DW'((sel + 1) * 16) : DW'(sel + 1);
  endfunction

  // Expected outputs per cycle, from start acceptance and the pass timing formulas
  task automatic fill(input logic [NV-1:0] starts, input int n, input int co_carry);
    int  s = -1000;
    bit  acc = 1'b0;
    for (int j = 0; j < n; j++) begin
      int r;
      int k;
      bit run;
      int t;
      if (starts[j] && (!acc || (j - s) > DONE_R)) begin
        s   = j;
        acc = 1'b1;
      end
      r   = j + 1 - s;
      k   = r - RUN_FIRST;
      run = acc && (r >= RUN_FIRST) && (r <= RUN_LAST);
      t   = r - A_LAT - RUN_FIRST;
      vec[j].start       = starts[j];
      vec[j].busy        = acc && (r >= 1) && (r <= DONE_R);
      vec[j].addr_en     = acc && (r >= 1) && (r <= RUN_LAST);
      vec[j].rden        = vec[j].addr_en;
      vec[j].mult_en     = acc && (r >= RUN_FIRST) && (r <= RUN_LAST + A_LAT);
      vec[j].accum_sload = run && ((k % STEPS) == 0);
      vec[j].count_sload = run ? 3'(k % STEPS) : 3'd0;
      vec[j].count_out   = !acc ? 2'(co_carry) : (r <= P_LAT) ? 2'd0 :
                           run ? 2'(k / STEPS) : 2'(GROUPS);
      vec[j].acc_valid   = acc && (t >= 0) && (t <= RUN_LAST - RUN_FIRST) &&
                           ((t % STEPS) == STEPS - 1);
      vec[j].done        = acc && (r == DONE_R);
      vec[j].q_a         = run ? bank_val((k % STEPS) / SEG, 1'b0) : 16'd0;
      vec[j].q_b         = run ? bank_val((k % STEPS) / SEG, 1'b1) : 16'd0;
    end
  endtask

  task automatic apply(input int n);
    vec_t e;
    for (int j = 0; j < n; j++) begin
      @(negedge clock);
      start = vec[j].start;
      sb_q.push_back(vec[j]);
      @(posedge clock);
      #1;
      e = sb_q.pop_front();
      check("busy", j + 1, 32'(busy), 32'(e.busy));
      check("done", j + 1, 32'(done), 32'(e.done));
      check("addr_en", j + 1, 32'(addr_en), 32'(e.addr_en));
      check("rden", j + 1, 32'(rden), 32'(e.rden));
      check("mult_en", j + 1, 32'(mult_en), 32'(e.mult_en));
      check("accum_sload", j + 1, 32'(accum_sload), 32'(e.accum_sload));
      check("count_sload", j + 1, 32'(count_sload), 32'(e.count_sload));
      check("count_out", j + 1, 32'(count_out), 32'(e.count_out));
      check("acc_valid", j + 1, 32'(acc_valid), 32'(e.acc_valid));
      check("q_a_mux", j + 1, 32'(q_a_mux), 32'(e.q_a));
      check("q_b_mux", j + 1, 32'(q_b_mux), 32'(e.q_b));
    end
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 0, 32'(busy), 32'd0);
    check({tag, "_addr_en"}, 0, 32'(addr_en), 32'd0);
    check({tag, "_rden"}, 0, 32'(rden), 32'd0);
    check({tag, "_mult_en"}, 0, 32'(mult_en), 32'd0);
    check({tag, "_accum_sload"}, 0, 32'(accum_sload), 32'd0);
    check({tag, "_count_sload"}, 0, 32'(count_sload), 32'd0);
    check({tag, "_count_out"}, 0, 32'(count_out), 32'd0);
    check({tag, "_acc_valid"}, 0, 32'(acc_valid), 32'd0);
    check({tag, "_q_a_mux"}, 0, 32'(q_a_mux), 32'd0);
    check({tag, "_q_b_mux"}, 0, 32'(q_b_mux), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    start3  = 1'b0;
    start1  = 1'b0;
    qa_all  = {16'd4, 16'd3, 16'd2, 16'd1};
    qb_all  = {16'h40, 16'h30, 16'h20, 16'h10};
    qa3_all = {16'd3, 16'd2, 16'd1};
    qb3_all = {16'h30, 16'h20, 16'h10};
    qa1_all = 16'd7;
    qb1_all = 16'h70;

    // Reset state while reset is held
    st_v = '0;
    fill(st_v, 3, 0);
    apply(3);
    @(negedge clock);
    reset = 1'b0;

    // Nominal pass
    st_v = '0;
    st_v[0] = 1'b1;
    fill(st_v, 30, 0);
    apply(30);

    // Start pulses while busy are ignored
    st_v = '0;
    st_v[0] = 1'b1;
    st_v[7] = 1'b1;
    st_v[20] = 1'b1;
    fill(st_v, 30, GROUPS);
    apply(30);

    // Async reset mid-RUN, then a fresh pass
    st_v = '0;
    st_v[0] = 1'b1;
    fill(st_v, 30, GROUPS);
    apply(10);
    #2 reset = 1'b1;
    #1 check_all_zero("rst_run");
    @(negedge clock);
    reset = 1'b0;
    fill(st_v, 30, 0);
    apply(30);

    // Reset with an acc_valid pending must flush the strobe
    fill(st_v, 30, GROUPS);
    apply(14);
    #2 reset = 1'b1;
    #1 check_all_zero("rst_pend");
    @(negedge clock);
    reset = 1'b0;
    st_v = '0;
    fill(st_v, 8, 0);
    apply(8);

    // Back-to-back passes with start held high
    st_v = '0;
    for (int i = 0; i <= 50; i++) st_v[i] = 1'b1;
    fill(st_v, 76, 0);
    apply(76);

    // Odd bank count (PI=3) and single bank (PI=1)
    @(negedge clock);
    start3 = 1'b1;
    start1 = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      logic [DW-1:0] e3;
      logic [DW-1:0] e1;
      @(posedge clock);
      #1;
      start3 = 1'b0;
      start1 = 1'b0;
      e3 = ((c >= 5) && (c <= 10)) ? DW'((c - 5) / 2 + 1) : 16'd0;
      e1 = ((c >= 5) && (c <= 12)) ? 16'd7 : 16'd0;
      check("pi3_q_a", c, 32'(q_a3), 32'(e3));
      check("pi3_q_b", c, 32'(q_b3), 32'(e3) * 32'd16);
      check("pi3_done", c, 32'(done3), 32'(c == 14));
      check("pi1_q_a", c, 32'(q_a1), 32'(e1));
      check("pi1_done", c, 32'(done1), 32'(c == 16));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
